// File: rtl/multi_pwm_pkg.sv
// Shared mode encodings and default sizing for the multi-channel PWM block.
// No logic; constants and types only.
// Imported by the prescaler and the top level.
package multi_pwm_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_t;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_PRESC_W = 8;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider producing one count tick every prescale_in+1 clocks while running.
// Tick is combinational from the divider register; the divider sits at 0 when not running.
// No backpressure; run_in low simply parks the divider.
module pwm_prescaler
    import multi_pwm_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               run_in,
    input  logic [PRESC_W-1:0] prescale_in,
    output logic               tick_out
);

    logic [PRESC_W-1:0] pcnt;

    // >= rather than == so a shrinking prescale_in never strands the count above it
    assign tick_out = run_in && (pcnt >= prescale_in);

    always_ff @(posedge clk_in) begin
        if (rst_in || !run_in || tick_out) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/multi_pwm_generator.sv
// Multi-channel edge/center-aligned PWM with glitch-free double-buffered duty updates.
// pwm_out is registered one clock after the counter value; period_start_out one clock after a boundary.
// duty_valid_in/duty_ready_out: ready drops while the pending buffer holds an unapplied duty set.
module multi_pwm_generator
    import multi_pwm_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    enable_in,
    input  logic                    center_in,
    input  logic [WIDTH-1:0]        period_in,
    input  logic [PRESC_W-1:0]      prescale_in,
    input  logic [NUM_CH*WIDTH-1:0] duty_in,
    input  logic                    duty_valid_in,
    output logic                    duty_ready_out,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start_out
);

    logic                    en_d;
    logic                    run;
    logic                    start;
    logic                    tick;
    logic                    center_eff;
    logic                    wrap;
    logic                    boundary;
    logic [WIDTH-1:0]        cnt;
    logic [WIDTH-1:0]        cnt_nxt;
    logic                    cnt_down;
    logic                    down_nxt;
    logic [WIDTH-1:0]        act_period;
    pwm_mode_t               act_mode;
    logic [NUM_CH*WIDTH-1:0] act_duty;
    logic [NUM_CH*WIDTH-1:0] pend_duty;
    logic                    pend_full;
    logic [NUM_CH-1:0]       pwm_nxt;

    // The enable rising clock is a load-only cycle; counting starts on the next clock
    // so the first period sees freshly loaded active copies, like any wrap boundary.
    assign start = enable_in && !en_d;
    assign run   = enable_in && en_d;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .run_in      (run),
        .prescale_in (prescale_in),
        .tick_out    (tick)
    );

    // Center mode with P=0 degenerates to edge mode with P=0.
    assign center_eff = (act_mode == MODE_CENTER) && (act_period != '0);
    assign wrap       = center_eff ? (cnt_down && (cnt == '0)) : (cnt >= act_period);
    assign boundary   = start || (tick && wrap);

    always_comb begin
        cnt_nxt  = cnt;
        down_nxt = cnt_down;
        if (!run) begin
            cnt_nxt  = '0;
            down_nxt = 1'b0;
        end else if (tick) begin
            if (wrap) begin
                cnt_nxt  = '0;
                down_nxt = 1'b0;
            end else if (center_eff) begin
                // The top value P-1 is held for two ticks: once going up, once going down.
                if (!cnt_down) begin
                    if (cnt >= act_period - 1'b1) begin
                        down_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign pwm_nxt[i] = run && (cnt < act_duty[i*WIDTH +: WIDTH]);
    end

    assign duty_ready_out = !pend_full;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            en_d             <= 1'b0;
            cnt              <= '0;
            cnt_down         <= 1'b0;
            act_period       <= '0;
            act_mode         <= MODE_EDGE;
            act_duty         <= '0;
            pend_duty        <= '0;
            pend_full        <= 1'b0;
            pwm_out          <= '0;
            period_start_out <= 1'b0;
        end else begin
            en_d             <= enable_in;
            cnt              <= cnt_nxt;
            cnt_down         <= down_nxt;
            pwm_out          <= pwm_nxt;
            period_start_out <= boundary;
            if (boundary) begin
                act_period <= period_in;
                act_mode   <= center_in ? MODE_CENTER : MODE_EDGE;
            end
            // Transfer and accept are mutually exclusive: accept needs empty, transfer needs full.
            if (pend_full && (boundary || !enable_in)) begin
                act_duty  <= pend_duty;
                pend_full <= 1'b0;
            end else if (duty_valid_in && !pend_full) begin
                pend_duty <= duty_in;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_pwm_generator.sv
// Directed bench for multi_pwm_generator: edge/center waveforms, duty handshake timing,
// enable gating and reset override, with per-clock expectations queued and popped.
module tb_multi_pwm_generator;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int PW  = 8;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              enable_in;
    logic              center_in;
    logic [W-1:0]      period_in;
    logic [PW-1:0]     prescale_in;
    logic [NCH*W-1:0]  duty_in;
    logic              duty_valid_in;
    logic              duty_ready_out;
    logic [NCH-1:0]    pwm_out;
    logic              period_start_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
        logic [7:0] mask;
    } exp_t;

    exp_t sb[$];

    multi_pwm_generator #(
        .NUM_CH  (NCH),
        .WIDTH   (W),
        .PRESC_W (PW)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .enable_in        (enable_in),
        .center_in        (center_in),
        .period_in        (period_in),
        .prescale_in      (prescale_in),
        .duty_in          (duty_in),
        .duty_valid_in    (duty_valid_in),
        .duty_ready_out   (duty_ready_out),
        .pwm_out          (pwm_out),
        .period_start_out (period_start_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [7:0] obs_word();
        return {duty_ready_out, period_start_out, 2'b00, pwm_out};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs_word() & e.mask, e.exp & e.mask);
        end
    endtask

    initial begin
        int         n;
        int         c;
        int         dv[NCH];
        int         cseq[8];
        logic [3:0] pw;
        exp_t       e;

        cseq = '{0, 1, 2, 3, 3, 2, 1, 0};

        rst_in        = 1'b1;
        enable_in     = 1'b0;
        center_in     = 1'b0;
        period_in     = 8'd9;
        prescale_in   = 8'd0;
        duty_in       = '0;
        duty_valid_in = 1'b0;
        step();
        step();
        rst_in = 1'b0;
        chk("reset_state", obs_word(), 8'h80);

        // Load duties while disabled: pending transfers straight to active.
        duty_in       = {8'd5, 8'd10, 8'd0, 8'd3};
        duty_valid_in = 1'b1;
        step();
        duty_valid_in = 1'b0;
        chk("hs_ready_low", {7'd0, duty_ready_out}, 8'h00);
        step();
        chk("dis_transfer_ready", {7'd0, duty_ready_out}, 8'h01);

        // Edge mode P=9, prescale 0.
        enable_in = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!period_start_out && n < 8);
        chk("edge_start_pulse", {7'd0, period_start_out}, 8'h01);

        for (int k = 1; k <= 40; k++) begin
            c = (k - 1) % 10;
            dv[0] = (k <= 30) ? 3 : 7;
            dv[1] = 0;
            dv[2] = 10;
            dv[3] = 5;
            for (int i = 0; i < NCH; i++) pw[i] = (c < dv[i]);
            e.tag  = $sformatf("edge_k%0d", k);
            e.exp  = {((k >= 26) && (k <= 29)) ? 1'b0 : 1'b1, (k % 10 == 0), 2'b00, pw};
            e.mask = 8'hCF;
            sb.push_back(e);
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            pop_chk();
            if (k == 25) begin
                duty_in       = {8'd5, 8'd10, 8'd0, 8'd7};
                duty_valid_in = 1'b1;
            end else begin
                duty_valid_in = 1'b0;
            end
        end

        // Disable for 20 clocks; outputs drop and a handshake applies immediately.
        enable_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            e.tag  = $sformatf("dis_k%0d", k);
            e.exp  = 8'h00;
            e.mask = 8'h4F;
            sb.push_back(e);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            pop_chk();
            if (k == 6) chk("dis_hs_ready_low", {7'd0, duty_ready_out}, 8'h00);
            if (k == 7) chk("dis_hs_ready_high", {7'd0, duty_ready_out}, 8'h01);
            if (k == 5) begin
                duty_in       = {8'd1, 8'd4, 8'd0, 8'd2};
                duty_valid_in = 1'b1;
            end else begin
                duty_valid_in = 1'b0;
            end
        end

        // Center mode P=4, prescale 1: 16-clock period.
        center_in   = 1'b1;
        period_in   = 8'd4;
        prescale_in = 8'd1;
        enable_in   = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!period_start_out && n < 8);
        chk("center_start_pulse", {7'd0, period_start_out}, 8'h01);

        dv[0] = 2;
        dv[1] = 0;
        dv[2] = 4;
        dv[3] = 1;
        for (int k = 1; k <= 32; k++) begin
            c = cseq[((k - 1) / 2) % 8];
            for (int i = 0; i < NCH; i++) pw[i] = (c < dv[i]);
            e.tag  = $sformatf("center_k%0d", k);
            e.exp  = {1'b1, (k % 16 == 0), 2'b00, pw};
            e.mask = 8'hCF;
            sb.push_back(e);
        end
        for (int k = 1; k <= 32; k++) begin
            step();
            pop_chk();
        end

        // Fill pending, then reset while channel 0 is high.
        duty_in       = {8'd1, 8'd4, 8'd0, 8'd3};
        duty_valid_in = 1'b1;
        step();
        duty_valid_in = 1'b0;
        chk("prereset_pwm0_ready", {6'd0, pwm_out[0], duty_ready_out}, 8'h02);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("postreset_state", obs_word(), 8'h80);

        for (int k = 1; k <= 20; k++) begin
            e.tag  = $sformatf("postreset_k%0d", k);
            e.exp  = 8'h80;
            e.mask = 8'h8F;
            sb.push_back(e);
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            pop_chk();
        end

        // New duty after reset takes effect only at the next boundary.
        duty_in       = {8'd0, 8'd0, 8'd0, 8'd2};
        duty_valid_in = 1'b1;
        step();
        duty_valid_in = 1'b0;
        chk("postreset_hs_ready_low", {7'd0, duty_ready_out}, 8'h00);
        n = 0;
        while (!duty_ready_out && n < 40) begin
            chk("postreset_pending_pwm0", {7'd0, pwm_out[0]}, 8'h00);
            step();
            n++;
        end
        chk("postreset_apply_at_boundary", {6'd0, duty_ready_out, period_start_out}, 8'h03);
        step();
        chk("postreset_new_duty_pwm0", {7'd0, pwm_out[0]}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_pwm_generator.md
MULTI_PWM_GENERATOR -- requirements
Module: multi_pwm_generator

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent PWM channels.
REQ-002 Parameter WIDTH, default 8: counter, period and duty width in bits.
REQ-003 Parameter PRESC_W, default 8: prescaler width in bits.
REQ-004 clk_in  input  1  sole clock, rising edge.
REQ-005 rst_in  input  1  reset, synchronous and active-high.
REQ-006 enable_in  input  1  run and stop control.
REQ-007 center_in  input  1  mode select: 0 is edge-aligned, 1 is center-aligned.
REQ-008 period_in  input  WIDTH  period top value P.
REQ-009 prescale_in  input  PRESC_W  one count tick every prescale_in+1 clocks.
REQ-010 duty_in  input  NUM_CH*WIDTH  packed duties, channel i in bits [i*WIDTH +: WIDTH].
REQ-011 duty_valid_in  input  1  duty_in offered.
REQ-012 duty_ready_out  output  1  pending buffer empty, so the block can accept.
REQ-013 pwm_out  output  NUM_CH  registered PWM outputs.
REQ-014 period_start_out  output  1  one-clock pulse marking each period start.

Function
REQ-015 The prescaler shall count 0..prescale_in and assert an internal tick on the clock at which it equals prescale_in, then return to 0.
REQ-016 Edge mode shall advance the counter 0,1..P,0 on each tick, giving a period of P+1 ticks.
REQ-017 Center mode shall count up 0..P-1, then down P-1..0, giving a period of 2P ticks; P=0 in center mode shall behave as edge mode with P=0.
REQ-018 A boundary is defined as the tick that returns the counter to the start of a period, plus the first clock after enable_in rises.
REQ-019 pwm_out[i] shall be registered as (counter < active_duty[i]), with exactly one clock of latency after the counter value.
REQ-020 Duty 0 shall hold the output low; duty greater than or equal to P+1 (edge mode) or P (center mode) shall hold it high.
REQ-021 Period, mode and duties shall be active copies, loaded only at a boundary, so no glitch occurs mid-period.
REQ-022 A handshake completes when duty_valid_in and duty_ready_out are both high on a clock edge; the block then latches duty_in into the pending buffer and drives duty_ready_out low on the next clock.
REQ-023 At a boundary with pending full, the block shall copy pending to active and drive duty_ready_out high on the next clock.
REQ-024 A handshake on the boundary cycle with pending empty shall fill pending, which then applies at the following boundary.
REQ-025 period_in and center_in shall be sampled at every boundary, independently of the handshake.
REQ-026 period_start_out shall pulse high for exactly one clock, one clock after each boundary.
REQ-027 With enable_in low, the prescaler and counter shall hold 0, pwm_out and period_start_out shall be 0, and a full pending buffer shall transfer to active on the next clock.

Reset
REQ-028 While rst_in is high on a clock edge, the block shall clear the prescaler, counter, active duties, active period and pending buffer, and set the mode to edge.
REQ-029 After reset, pwm_out shall be 0, period_start_out 0 and duty_ready_out 1.
REQ-030 Reset asserted mid-period shall override every other event in that cycle, including a handshake or a boundary.

Structure
REQ-031 Package multi_pwm_pkg shall hold the MODE_EDGE/MODE_CENTER encodings and the default WIDTH, PRESC_W and NUM_CH constants.
REQ-032 The prescaler and tick generation shall be one sub-module, pwm_prescaler; per-channel compare shall be a generate loop in the top module.

Verification
REQ-033 Edge mode, prescale 0, P=9, duty ch0=3 -> pwm_out[0] high 3 of every 10 clocks; period_start_out pulses every 10 clocks.
REQ-034 Duties ch1=0 and ch2=10 with P=9 -> pwm_out[1] constantly 0 and pwm_out[2] constantly 1.
REQ-035 Duty ch0 changed 3->7 by a handshake at counter=5 -> current period stays 3 high, next period 7 high; duty_ready_out stays 0 until one clock after the boundary.
REQ-036 Center mode, P=4, prescale 1, duty 2 -> period 16 clocks with 8 high clocks, centred on the counter-0 phase.
REQ-037 rst_in pulsed for one clock while pwm_out[0]=1 and pending full -> next clock pwm_out=0, duty_ready_out=1, and duties stay 0 until a new handshake and boundary.
REQ-038 enable_in low for 20 clocks -> pwm_out=0 within one clock; on re-enable, counter restarts at 0 and period_start_out pulses once.
